// File: rtl/csr_trap_file.sv
// rtl/csr_trap_file.sv - machine-mode CSR file with trap/mret redirect and MMU (satp) controls
// Define CSR_TRAP_COUNTERS_EN to build the mcycle/minstret counters and their high halves.
module csr_trap_file #(
  parameter int          CYCLE_W     = 64,
  parameter logic [31:0] MVENDORID   = 32'h79737978,
  parameter logic [31:0] MARCHID     = 32'h015fdf0c,
  parameter logic [31:0] RESET_MTVEC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        illegal,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        inst_mret,
  input  logic        irq_ext,
  input  logic        irq_soft,
  input  logic        irq_timer,
  output logic        trap_en,
  output logic [31:0] trap_pc,
  output logic        mmu_on,
  output logic [19:0] ppn,
  output logic        tlb_flush
);

  localparam logic [11:0] A_SATP      = 12'h180;
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  localparam logic [1:0]  OP_NONE     = 2'b00;
  localparam logic [1:0]  OP_WRITE    = 2'b01;
  localparam logic [1:0]  OP_SET      = 2'b10;
  localparam logic [1:0]  OP_CLEAR    = 2'b11;

  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;
  localparam logic [31:0] MCAUSE_MASK = 32'h8000_001F;

  if (CYCLE_W < 33 || CYCLE_W > 64) begin : g_cycle_w_range
    $error("csr_trap_file: CYCLE_W must be within 33..64");
  end

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] satp_q, satp_d;

  logic [31:0] cnt_cycle_lo, cnt_cycle_hi, cnt_instret_lo, cnt_instret_hi;
  logic [31:0] mip_val, mstatus_val, old_val, new_val, tvec_base, int_active;
  logic        addr_known, addr_ro, write_eff, int_pend, exc_hit;
  logic [4:0]  int_code, exc_code;
  logic        take_int, take_exc, take_mret, take_csr;

  assign mip_val     = {20'h0, irq_ext, 3'b000, irq_timer, 3'b000, irq_soft, 3'b000};
  assign mstatus_val = {19'h0, 2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};

  always_comb begin
    old_val    = 32'h0;
    addr_known = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr)
      A_MSTATUS:   old_val = mstatus_val;
      A_MIE:       old_val = mie_q;
      A_MTVEC:     old_val = mtvec_q;
      A_MEPC:      old_val = mepc_q;
      A_MCAUSE:    old_val = mcause_q;
      A_MTVAL:     old_val = mtval_q;
      A_MSCRATCH:  old_val = mscratch_q;
      A_SATP:      old_val = satp_q;
      A_MCYCLE:    old_val = cnt_cycle_lo;
      A_MCYCLEH:   old_val = cnt_cycle_hi;
      A_MINSTRET:  old_val = cnt_instret_lo;
      A_MINSTRETH: old_val = cnt_instret_hi;
      A_MIP: begin
        old_val = mip_val;
        addr_ro = 1'b1;
      end
      A_MVENDORID: begin
        old_val = MVENDORID;
        addr_ro = 1'b1;
      end
      A_MARCHID: begin
        old_val = MARCHID;
        addr_ro = 1'b1;
      end
      default:     addr_known = 1'b0;
    endcase
  end

  // set/clear with a zero operand is a pure read and must not modify anything
  assign write_eff = (csr_op == OP_WRITE) || (csr_op[1] && (wdata != 32'h0));
  assign illegal   = valid && (csr_op != OP_NONE) && (!addr_known || (addr_ro && write_eff));
  assign rdata     = old_val;

  always_comb begin
    new_val = wdata;
    case (csr_op)
      OP_SET:   new_val = old_val | wdata;
      OP_CLEAR: new_val = old_val & ~wdata;
      default:  new_val = wdata;
    endcase
  end

  assign int_active = mie_q & mip_val;
  assign int_pend   = mstatus_mie_q && (int_active != 32'h0);

  always_comb begin
    int_code = 5'd7;
    if (int_active[11]) int_code = 5'd11;
    else if (int_active[3]) int_code = 5'd3;
  end

  // A pipeline-reported exception outranks the locally detected illegal CSR access
  assign exc_hit   = exc_valid || illegal;
  assign exc_code  = exc_valid ? exc_cause : 5'd2;
  assign take_int  = valid && int_pend;
  assign take_exc  = valid && !int_pend && exc_hit;
  assign take_mret = valid && !int_pend && !exc_hit && inst_mret;
  assign take_csr  = valid && !int_pend && !exc_hit && !inst_mret && write_eff;

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign trap_en   = take_int || take_exc || take_mret;
  assign tlb_flush = take_csr && (csr_addr == A_SATP);
  assign mmu_on    = satp_q[31];
  assign ppn       = satp_q[19:0];

  always_comb begin
    trap_pc = tvec_base;
    if (take_mret) trap_pc = mepc_q;
    else if (take_int && (mtvec_q[1:0] == 2'b01)) trap_pc = tvec_base + {25'h0, int_code, 2'b00};
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mscratch_d     = mscratch_q;
    satp_d         = satp_q;
    if (take_int || take_exc) begin
      mepc_d         = exc_pc & ~32'h3;
      mcause_d       = {take_int, 26'h0, take_int ? int_code : exc_code};
      mtval_d        = take_int ? 32'h0 : exc_tval;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (take_csr) begin
      case (csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = new_val[3];
          mstatus_mpie_d = new_val[7];
        end
        A_MIE:      mie_d      = new_val & MIE_MASK;
        A_MTVEC:    mtvec_d    = {new_val[31:2], new_val[1] ? mtvec_q[1:0] : new_val[1:0]};
        A_MEPC:     mepc_d     = new_val & ~32'h3;
        A_MCAUSE:   mcause_d   = new_val & MCAUSE_MASK;
        A_MTVAL:    mtval_d    = new_val;
        A_MSCRATCH: mscratch_d = new_val;
        A_SATP:     satp_d     = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
      mscratch_q     <= 32'h0;
      satp_q         <= 32'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mscratch_q     <= mscratch_d;
      satp_q         <= satp_d;
    end
  end

`ifdef CSR_TRAP_COUNTERS_EN
  logic [CYCLE_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [63:0]        mcycle_x, minstret_x;

  assign mcycle_x       = 64'(mcycle_q);
  assign minstret_x     = 64'(minstret_q);
  assign cnt_cycle_lo   = mcycle_x[31:0];
  assign cnt_cycle_hi   = mcycle_x[63:32];
  assign cnt_instret_lo = minstret_x[31:0];
  assign cnt_instret_hi = minstret_x[63:32];

  // A software write to either half replaces that half and wins over the increment
  always_comb begin
    mcycle_d   = mcycle_q + CYCLE_W'(1);
    minstret_d = minstret_q;
    if (valid && !take_int && !take_exc) minstret_d = minstret_q + CYCLE_W'(1);
    if (take_csr) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_d   = CYCLE_W'({mcycle_x[63:32], new_val});
        A_MCYCLEH:   mcycle_d   = CYCLE_W'({new_val, mcycle_x[31:0]});
        A_MINSTRET:  minstret_d = CYCLE_W'({minstret_x[63:32], new_val});
        A_MINSTRETH: minstret_d = CYCLE_W'({new_val, minstret_x[31:0]});
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  assign cnt_cycle_lo   = 32'h0;
  assign cnt_cycle_hi   = 32'h0;
  assign cnt_instret_lo = 32'h0;
  assign cnt_instret_hi = 32'h0;
`endif

endmodule

// File: tb/tb_csr_trap_file.sv
// tb/tb_csr_trap_file.sv - directed and randomized self-checking bench for csr_trap_file
module tb_csr_trap_file;
  localparam int CW = 64;
  localparam longint unsigned CMASK = (CW >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
`ifdef CSR_TRAP_COUNTERS_EN
  localparam logic [31:0] CNT_ONE = 32'd1;
`else
  localparam logic [31:0] CNT_ONE = 32'd0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        illegal;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        inst_mret = 1'b0;
  logic        irq_ext = 1'b0, irq_soft = 1'b0, irq_timer = 1'b0;
  logic        trap_en;
  logic [31:0] trap_pc;
  logic        mmu_on;
  logic [19:0] ppn;
  logic        tlb_flush;

  always #5 clock = ~clock;

  csr_trap_file #(.CYCLE_W(CW)) dut (
    .clock(clock), .reset(reset), .valid(valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .wdata(wdata), .rdata(rdata), .illegal(illegal), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval), .inst_mret(inst_mret),
    .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer), .trap_en(trap_en),
    .trap_pc(trap_pc), .mmu_on(mmu_on), .ppn(ppn), .tlb_flush(tlb_flush)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state, kept as architectural values
  bit              m_mie_b, m_mpie_b;
  logic [31:0]     r_mie, r_mtvec, r_mepc, r_mcause, r_mtval, r_mscratch, r_satp;
  longint unsigned m_cycle, m_instret;

  logic [31:0] e_rdata, e_trap_pc, e_new;
  bit          e_illegal, e_trap_en, e_tlb, d_int, d_exc, d_mret, d_csr;
  int          e_code;

  logic [11:0] addrs [17] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'h180, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11,
                              12'hF12, 12'h7C0, 12'h001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie_b = 0; m_mpie_b = 0;
    r_mie = 0; r_mtvec = 0; r_mepc = 0; r_mcause = 0; r_mtval = 0; r_mscratch = 0; r_satp = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  function automatic logic [31:0] cnt_read(input logic [11:0] a);
`ifdef CSR_TRAP_COUNTERS_EN
    case (a)
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      default: return m_instret[63:32];
    endcase
`else
    return (a == 12'h0) ? 32'h1 : 32'h0;
`endif
  endfunction

  task automatic model_read(input logic [11:0] a, output logic [31:0] v, output bit known, output bit ro);
    known = 1; ro = 0; v = 0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mie_b) << 3) | (32'(m_mpie_b) << 7);
      12'h304: v = r_mie;
      12'h305: v = r_mtvec;
      12'h340: v = r_mscratch;
      12'h341: v = r_mepc;
      12'h342: v = r_mcause;
      12'h343: v = r_mtval;
      12'h180: v = r_satp;
      12'h344: begin v = (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3); ro = 1; end
      12'hF11: begin v = 32'h79737978; ro = 1; end
      12'hF12: begin v = 32'h015fdf0c; ro = 1; end
      12'hB00, 12'hB80, 12'hB02, 12'hB82: v = cnt_read(a);
      default: known = 0;
    endcase
  endtask

  task automatic model_eval();
    bit known, ro, wr;
    logic [31:0] old, mip;
    int prio [3] = '{11, 3, 7};
    model_read(csr_addr, old, known, ro);
    e_rdata = old;
    wr = (csr_op == 2'd1) || (csr_op >= 2'd2 && wdata != 0);
    e_illegal = valid && csr_op != 0 && (!known || (ro && wr));
    mip = (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
    e_code = -1;
    foreach (prio[i]) if (e_code < 0 && r_mie[prio[i]] && mip[prio[i]]) e_code = prio[i];
    d_int  = valid && m_mie_b && e_code >= 0;
    d_exc  = valid && !d_int && (exc_valid || e_illegal);
    d_mret = valid && !d_int && !d_exc && inst_mret;
    d_csr  = valid && !d_int && !d_exc && !d_mret && wr;
    e_trap_en = d_int || d_exc || d_mret;
    if (d_mret) e_trap_pc = r_mepc;
    else e_trap_pc = (r_mtvec & ~32'h3) + ((d_int && r_mtvec[1:0] == 2'd1) ? 32'(4 * e_code) : 32'h0);
    e_tlb = d_csr && csr_addr == 12'h180;
    case (csr_op)
      2'd2:    e_new = old | wdata;
      2'd3:    e_new = old & ~wdata;
      default: e_new = wdata;
    endcase
  endtask

  task automatic model_commit();
    longint unsigned nc, ni;
    nc = (m_cycle + 1) & CMASK;
    ni = (!valid || d_int || d_exc) ? m_instret : ((m_instret + 1) & CMASK);
    if (d_int || d_exc) begin
      r_mepc   = exc_pc & ~32'h3;
      r_mcause = d_int ? (32'h8000_0000 | 32'(e_code)) : 32'(exc_valid ? exc_cause : 5'd2);
      r_mtval  = d_int ? 32'h0 : exc_tval;
      m_mpie_b = m_mie_b;
      m_mie_b  = 0;
    end else if (d_mret) begin
      m_mie_b  = m_mpie_b;
      m_mpie_b = 1;
    end else if (d_csr) begin
      case (csr_addr)
        12'h300: begin m_mie_b = e_new[3]; m_mpie_b = e_new[7]; end
        12'h304: r_mie = e_new & 32'h888;
        12'h305: r_mtvec = (e_new[1:0] <= 2'd1) ? e_new : {e_new[31:2], r_mtvec[1:0]};
        12'h341: r_mepc = e_new & ~32'h3;
        12'h342: r_mcause = e_new & 32'h8000_001F;
        12'h343: r_mtval = e_new;
        12'h340: r_mscratch = e_new;
        12'h180: r_satp = e_new;
        12'hB00: nc = {m_cycle[63:32], e_new} & CMASK;
        12'hB80: nc = {e_new, m_cycle[31:0]} & CMASK;
        12'hB02: ni = {m_instret[63:32], e_new} & CMASK;
        12'hB82: ni = {e_new, m_instret[31:0]} & CMASK;
        default: ;
      endcase
    end
    m_cycle = nc;
    m_instret = ni;
  endtask

  task automatic settle();
    @(negedge clock);
    model_eval();
    chk("rdata", rdata, e_rdata);
    chk("illegal", 32'(illegal), 32'(e_illegal));
    chk("trap_en", 32'(trap_en), 32'(e_trap_en));
    if (e_trap_en) chk("trap_pc", trap_pc, e_trap_pc);
    chk("tlb_flush", 32'(tlb_flush), 32'(e_tlb));
    chk("mmu_on", 32'(mmu_on), 32'(r_satp[31]));
    chk("ppn", 32'(ppn), 32'(r_satp[19:0]));
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic clr();
    valid = 0; csr_addr = 0; csr_op = 0; wdata = 0;
    exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; inst_mret = 0;
    irq_ext = 0; irq_soft = 0; irq_timer = 0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    clr(); valid = 1; csr_addr = a; csr_op = op; wdata = d;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    clr(); csr_addr = a;
    settle();
    chk(tag, rdata, exp);
    advance();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    model_reset();

    settle();
    chk("idle_rdata", rdata, 32'h0);
    chk("idle_trap_en", 32'(trap_en), 32'h0);
    chk("idle_tlb_flush", 32'(tlb_flush), 32'h0);
    chk("reset_mmu_on", 32'(mmu_on), 32'h0);
    advance();
    rd_chk("mstatus_reset", 12'h300, 32'h1800);
    rd_chk("mvendorid", 12'hF11, 32'h79737978);
    rd_chk("marchid", 12'hF12, 32'h015fdf0c);

    csr(12'h305, 2'd1, 32'h8000_0001); tick();
    csr(12'h300, 2'd2, 32'h8); tick();
    csr(12'h304, 2'd2, 32'h80); tick();
    clr(); valid = 1; irq_timer = 1;
    settle();
    chk("timer_trap_en", 32'(trap_en), 32'h1);
    chk("timer_vector_pc", trap_pc, 32'h8000_001C);
    advance();
    rd_chk("timer_mcause", 12'h342, 32'h8000_0007);
    rd_chk("timer_mstatus", 12'h300, 32'h1880);

    csr(12'h305, 2'd1, 32'h8000_0000); tick();
    csr(12'h300, 2'd2, 32'h8); tick();
    clr(); valid = 1; exc_valid = 1; exc_cause = 5'd11; exc_pc = 32'h8000_0100; exc_tval = 32'h1234;
    settle();
    chk("exc_trap_pc", trap_pc, 32'h8000_0000);
    advance();
    rd_chk("exc_mepc", 12'h341, 32'h8000_0100);
    rd_chk("exc_mcause", 12'h342, 32'h0000_000B);
    rd_chk("exc_mstatus", 12'h300, 32'h1880);
    clr(); valid = 1; inst_mret = 1;
    settle();
    chk("mret_trap_pc", trap_pc, 32'h8000_0100);
    advance();
    rd_chk("mret_mstatus", 12'h300, 32'h1888);

    csr(12'h304, 2'd2, 32'h800); tick();
    csr(12'h340, 2'd1, 32'hDEAD_BEEF); irq_ext = 1; irq_timer = 1;
    settle();
    chk("preempt_trap_en", 32'(trap_en), 32'h1);
    advance();
    rd_chk("preempt_mcause", 12'h342, 32'h8000_000B);
    rd_chk("preempt_mscratch", 12'h340, 32'h0);
    clr(); csr_addr = 12'hB02; tick();

    csr(12'h180, 2'd1, 32'h8001_2345);
    settle();
    chk("satp_tlb_flush", 32'(tlb_flush), 32'h1);
    advance();
    clr();
    settle();
    chk("satp_flush_pulse", 32'(tlb_flush), 32'h0);
    chk("satp_mmu_on", 32'(mmu_on), 32'h1);
    chk("satp_ppn", 32'(ppn), 32'h12345);
    advance();
    csr(12'h180, 2'd2, 32'h0);
    settle();
    chk("satp_set0_flush", 32'(tlb_flush), 32'h0);
    advance();

    csr(12'hF11, 2'd1, 32'h5);
    settle();
    chk("ro_write_illegal", 32'(illegal), 32'h1);
    advance();
    rd_chk("illegal_mcause", 12'h342, 32'h2);
    csr(12'hF11, 2'd2, 32'h0);
    settle();
    chk("ro_set0_legal", 32'(illegal), 32'h0);
    advance();
    csr(12'h7C0, 2'd3, 32'h0);
    settle();
    chk("unknown_illegal", 32'(illegal), 32'h1);
    advance();

    csr(12'hB00, 2'd1, 32'hFFFF_FFFF); tick();
    clr(); tick(); tick();
    rd_chk("mcycle_wrap_lo", 12'hB00, CNT_ONE);
    rd_chk("mcycle_wrap_hi", 12'hB80, CNT_ONE);

    for (int n = 0; n < 400; n++) begin
      clr();
      valid     = ($urandom_range(0, 3) != 0);
      csr_addr  = addrs[$urandom_range(0, 16)];
      csr_op    = 2'($urandom_range(0, 3));
      wdata     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_cause = 5'($urandom_range(0, 15));
      exc_pc    = $urandom;
      exc_tval  = $urandom;
      inst_mret = ($urandom_range(0, 14) == 0);
      irq_ext   = ($urandom_range(0, 7) == 0);
      irq_soft  = ($urandom_range(0, 7) == 0);
      irq_timer = ($urandom_range(0, 7) == 0);
      tick();
    end

    clr(); valid = 1; exc_valid = 1; exc_pc = 32'h1234_5678; reset = 1;
    @(posedge clock);
    #1 reset = 0;
    clr();
    model_reset();
    rd_chk("reset_over_trap_mepc", 12'h341, 32'h0);
    rd_chk("reset_over_trap_mstatus", 12'h300, 32'h1800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
